daisy_chain_slave_n: RTL and testbench

Parametrised daisy-chain SPI slave, the next generation of the fixed 8-bit chain slave. It waits for the upstream slave's done flag, shifts in a WIDTH-bit frame on sdi, and presents that frame locally with a valid pulse. It then shifts either the received frame or a locally supplied response out on sdo, and raises done to enable the next slave in the chain. Adds configurable width, bit order and forward/respond mode, chip-select abort, and asynchronous reset.

---
 rtl/daisy_chain_pkg.sv | 23 ++
 rtl/daisy_chain_slave_n.sv | 181 ++++++++++++++++++
 tb/tb_daisy_chain_slave_n.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/daisy_chain_pkg.sv
// -----------------------------------------------------------------------------
// daisy_chain_pkg
//   Types and helpers shared by the daisy-chain SPI slaves.
//   - dc_state_e  : frame-level state of a chain slave
//   - wire_to_bit : maps a wire (shift) index to a frame bit index
// -----------------------------------------------------------------------------
package daisy_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } dc_state_e;

  // Wire index 0 is the first bit on the line. With LSB-first ordering it is
  // frame bit 0; with MSB-first ordering it is frame bit width-1.
  function automatic int wire_to_bit(input int wire_idx, input int width,
                                     input bit lsb_first);
    return lsb_first ? wire_idx : (width - 1 - wire_idx);
  endfunction

endpackage

// File: rtl/daisy_chain_slave_n.sv
// -----------------------------------------------------------------------------
// daisy_chain_slave_n
//   Parametrised daisy-chain SPI slave. Once the upstream slave raises
//   done_prev, it shifts in a WIDTH-bit frame on sdi and presents it on
//   rx_data with a one-cycle rx_valid pulse. It then shifts out either the
//   received frame (FORWARD=1) or tx_data (FORWARD=0) on sdo and raises done
//   to enable the next slave. cs high during a transfer aborts the frame.
//
// Parameters
//   WIDTH     : frame length in bits (>= 2)
//   LSB_FIRST : 1 = frame bit 0 first on the wire, 0 = bit WIDTH-1 first
//   FORWARD   : 1 = retransmit received frame, 0 = transmit tx_data
//
// Ports
//   sclk      in   SPI clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   cs        in   chip select, active low
//   sdi       in   serial data from master / upstream slave
//   done_prev in   upstream done, enables capture
//   tx_data   in   local response frame (FORWARD=0), sampled on last rx edge
//   rx_data   out  last complete received frame
//   rx_valid  out  one-cycle pulse when rx_data updates
//   sdo       out  serial data to downstream slave
//   done      out  frame forwarded, enables downstream
//   busy      out  high in RECEIVE or SEND
// -----------------------------------------------------------------------------
module daisy_chain_slave_n
  import daisy_chain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit FORWARD   = 1'b1
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             sdi,
  input  logic             done_prev,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sdo,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  dc_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_data_d;
  logic             rx_valid_d, sdo_d, done_d;

  // Frame bit addressed by the current wire index. cnt is held at 0 in IDLE,
  // so the same selector serves the IDLE capture edge (wire index 0).
  logic [IW-1:0]    bit_sel;
  logic [WIDTH-1:0] rx_with_bit;

  assign bit_sel = IW'(wire_to_bit(int'(cnt_q), WIDTH, LSB_FIRST));

  always_comb begin
    rx_with_bit          = rx_shift_q;
    rx_with_bit[bit_sel] = sdi;
  end

  assign busy = (state_q == ST_RECEIVE) || (state_q == ST_SEND);

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block leaves a value unassigned and no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data;
    sdo_d      = sdo;
    done_d     = done;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        sdo_d  = 1'b0;
        done_d = 1'b0;
        if (!cs && done_prev) begin
          rx_shift_d = rx_with_bit;
          cnt_d      = CNT_ONE;
          state_d    = ST_RECEIVE;
        end
      end

      ST_RECEIVE: begin
        if (cs) begin
          // Abort: rx_data keeps the previous frame, no valid pulse.
          state_d = ST_IDLE;
          cnt_d   = '0;
          sdo_d   = 1'b0;
          done_d  = 1'b0;
        end else begin
          rx_shift_d = rx_with_bit;
          if (cnt_q == LAST_IDX) begin
            rx_data_d  = rx_with_bit;
            rx_valid_d = 1'b1;
            tx_shift_d = FORWARD ? rx_with_bit : tx_data;
            cnt_d      = '0;
            state_d    = ST_SEND;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_SEND: begin
        if (cs) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sdo_d   = 1'b0;
          done_d  = 1'b0;
        end else begin
          sdo_d = tx_shift_q[bit_sel];
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        sdo_d = 1'b0;
        if (!cs && done_prev) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sdo_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the shift registers are reset along with the control state; they
  // are only WIDTH bits each, and a known value keeps rx_data and sdo clean
  // immediately after reset.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      sdo        <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      sdo        <= sdo_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_daisy_chain_slave_n.sv
// -----------------------------------------------------------------------------
// tb_daisy_chain_slave_n
//   Two instances: u8 (WIDTH=8, LSB first, forward) and u16 (WIDTH=16,
//   MSB first, respond with tx_data). Stimulus pushes the expected frame into
//   a per-instance queue; a monitor per instance pops it when rx_valid is
//   seen and then follows the sdo bits and the done flag.
// -----------------------------------------------------------------------------
module tb_daisy_chain_slave_n;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] tx;
    int          n_sdo;
    bit          chk_done;
  } exp_t;

  logic        sclk;
  logic        rst_n8, rst_n16;
  logic        cs_a[2], dp_a[2], sdi_a[2];
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;
  logic [7:0]  rx_data8;
  logic [15:0] rx_data16;
  logic        rxv[2], sdo_w[2], done_w[2], busy_w[2];
  logic [15:0] rxd[2];

  exp_t q8[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_errors = 0;

  assign rxd[0] = {8'h00, rx_data8};
  assign rxd[1] = rx_data16;

  daisy_chain_slave_n #(.WIDTH(8), .LSB_FIRST(1'b1), .FORWARD(1'b1)) u8 (
    .sclk(sclk), .rst_n(rst_n8), .cs(cs_a[0]), .sdi(sdi_a[0]),
    .done_prev(dp_a[0]), .tx_data(tx_data8), .rx_data(rx_data8),
    .rx_valid(rxv[0]), .sdo(sdo_w[0]), .done(done_w[0]), .busy(busy_w[0])
  );

  daisy_chain_slave_n #(.WIDTH(16), .LSB_FIRST(1'b0), .FORWARD(1'b0)) u16 (
    .sclk(sclk), .rst_n(rst_n16), .cs(cs_a[1]), .sdi(sdi_a[1]),
    .done_prev(dp_a[1]), .tx_data(tx_data16), .rx_data(rx_data16),
    .rx_valid(rxv[1]), .sdo(sdo_w[1]), .done(done_w[1]), .busy(busy_w[1])
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic bit wire_bit(input logic [15:0] f, input int i,
                                  input int w, input bit lsb);
    return lsb ? f[i] : f[w-1-i];
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int m, input logic [15:0] rx,
                          input logic [15:0] tx, input int n, input bit cd);
    exp_t e;
    e.rx = rx; e.tx = tx; e.n_sdo = n; e.chk_done = cd;
    if (m == 0) q8.push_back(e);
    else        q16.push_back(e);
  endtask

  // Drives wire bits 0..nbits-1 of frame f, one per edge; returns right
  // after the edge that captures the last driven bit.
  task automatic drive_bits(input int m, input logic [15:0] f, input int w,
                            input bit lsb, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      cs_a[m]  = 1'b0;
      dp_a[m]  = 1'b1;
      sdi_a[m] = wire_bit(f, i, w, lsb);
      @(posedge sclk);
    end
  endtask

  task automatic run_monitor(input int m, input int w, input bit lsb);
    exp_t e;
    bit   have;
    forever begin
      @(negedge sclk);
      if (rxv[m]) begin
        have = 1'b0;
        if (m == 0 && q8.size() > 0) begin
          e = q8.pop_front(); have = 1'b1;
        end else if (m == 1 && q16.size() > 0) begin
          e = q16.pop_front(); have = 1'b1;
        end
        if (!have) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rx_valid[%0d]: got pulse with rx_data %h, required none",
                   m, rxd[m]);
        end else begin
          check($sformatf("rx_data[%0d]", m), rxd[m], e.rx);
          for (int k = 0; k < e.n_sdo; k++) begin
            @(negedge sclk);
            if (k == 0) begin
              check($sformatf("rx_valid_pulse[%0d]", m), 16'(rxv[m]), 16'h0);
              check($sformatf("busy_send[%0d]", m), 16'(busy_w[m]), 16'h1);
            end
            check($sformatf("sdo[%0d] bit %0d", m, k), 16'(sdo_w[m]),
                  16'(wire_bit(e.tx, k, w, lsb)));
            if (k == w - 1)
              check($sformatf("done_early[%0d]", m), 16'(done_w[m]), 16'h0);
          end
          if (e.chk_done) begin
            @(negedge sclk);
            check($sformatf("done_rise[%0d]", m), 16'(done_w[m]), 16'h1);
          end
        end
      end
    end
  endtask

  initial run_monitor(0, 8, 1'b1);
  initial run_monitor(1, 16, 1'b0);

  initial begin : stim
    rst_n8    = 1'b0;
    rst_n16   = 1'b0;
    tx_data8  = 8'h00;
    tx_data16 = 16'h1234;
    for (int m = 0; m < 2; m++) begin
      cs_a[m] = 1'b1; dp_a[m] = 1'b0; sdi_a[m] = 1'b0;
    end
    repeat (2) @(negedge sclk);

    // Reset state of both instances.
    for (int m = 0; m < 2; m++) begin
      check($sformatf("reset rx_data[%0d]", m), rxd[m], 16'h0);
      check($sformatf("reset rx_valid[%0d]", m), 16'(rxv[m]), 16'h0);
      check($sformatf("reset sdo[%0d]", m), 16'(sdo_w[m]), 16'h0);
      check($sformatf("reset done[%0d]", m), 16'(done_w[m]), 16'h0);
      check($sformatf("reset busy[%0d]", m), 16'(busy_w[m]), 16'h0);
    end
    rst_n8  = 1'b1;
    rst_n16 = 1'b1;

    // Handshake gating: cs low but no upstream done -> stays idle.
    @(negedge sclk);
    cs_a[0] = 1'b0; dp_a[0] = 1'b0; sdi_a[0] = 1'b1;
    repeat (4) @(posedge sclk);
    @(negedge sclk);
    check("gate busy", 16'(busy_w[0]), 16'h0);
    check("gate done", 16'(done_w[0]), 16'h0);

    // Forward, LSB first: 0xA5, then hold done_prev past DONE.
    push_exp(0, 16'h00A5, 16'h00A5, 8, 1'b1);
    drive_bits(0, 16'h00A5, 8, 1'b1, 8);
    repeat (12) @(posedge sclk);          // edges 9..20
    @(negedge sclk);
    check("done hold", 16'(done_w[0]), 16'h1);
    dp_a[0] = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    check("done release", 16'(done_w[0]), 16'h0);
    cs_a[0] = 1'b1;

    // Chip-select abort after 5 received bits.
    drive_bits(0, 16'h003C, 8, 1'b1, 5);
    @(negedge sclk);
    check("abort busy before", 16'(busy_w[0]), 16'h1);
    cs_a[0] = 1'b1; dp_a[0] = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    check("abort busy", 16'(busy_w[0]), 16'h0);
    check("abort sdo", 16'(sdo_w[0]), 16'h0);
    check("abort rx_data kept", rxd[0], 16'h00A5);
    repeat (4) @(negedge sclk);

    // Async reset mid-SEND (after wire bit 3 of 0x5A is on sdo).
    push_exp(0, 16'h005A, 16'h005A, 3, 1'b0);
    drive_bits(0, 16'h005A, 8, 1'b1, 8);
    repeat (4) @(posedge sclk);           // edges 9..12
    #1;
    check("sdo pre-reset", 16'(sdo_w[0]), 16'h1);
    #1 rst_n8 = 1'b0;
    #1;
    check("async rst sdo", 16'(sdo_w[0]), 16'h0);
    check("async rst done", 16'(done_w[0]), 16'h0);
    check("async rst busy", 16'(busy_w[0]), 16'h0);
    check("async rst rx_valid", 16'(rxv[0]), 16'h0);
    check("async rst rx_data", rxd[0], 16'h0);
    @(negedge sclk);
    cs_a[0] = 1'b1; dp_a[0] = 1'b0;
    @(negedge sclk);
    rst_n8 = 1'b1;

    // Full frame after reset release.
    push_exp(0, 16'h00C3, 16'h00C3, 8, 1'b1);
    drive_bits(0, 16'h00C3, 8, 1'b1, 8);
    repeat (9) @(posedge sclk);           // edges 9..17
    @(negedge sclk);
    dp_a[0] = 1'b0; cs_a[0] = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check("done clear after C3", 16'(done_w[0]), 16'h0);

    // Respond, MSB first: receive 0xBEEF, send tx_data 0x1234.
    tx_data16 = 16'h1234;
    push_exp(1, 16'hBEEF, 16'h1234, 16, 1'b1);
    drive_bits(1, 16'hBEEF, 16, 1'b0, 16);
    @(negedge sclk);
    tx_data16 = 16'h0000;
    repeat (17) @(posedge sclk);          // edges 17..33
    @(negedge sclk);
    check("u16 done hold", 16'(done_w[1]), 16'h1);
    dp_a[1] = 1'b0; cs_a[1] = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check("u16 done release", 16'(done_w[1]), 16'h0);

    // tx_data is sampled on the last receive edge only.
    tx_data16 = 16'hFFFF;
    push_exp(1, 16'h0F0F, 16'h8001, 16, 1'b1);
    drive_bits(1, 16'h0F0F, 16, 1'b0, 15);
    @(negedge sclk);
    tx_data16 = 16'h8001;
    sdi_a[1]  = wire_bit(16'h0F0F, 15, 16, 1'b0);
    @(posedge sclk);                      // edge 16
    @(negedge sclk);
    tx_data16 = 16'h0000;
    repeat (17) @(posedge sclk);          // edges 17..33
    @(negedge sclk);
    dp_a[1] = 1'b0; cs_a[1] = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check("u16 done clear 2", 16'(done_w[1]), 16'h0);

    repeat (4) @(negedge sclk);
    check("q8 drained", 16'(q8.size()), 16'h0);
    check("q16 drained", 16'(q16.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
